// File: rtl/tx_symbol_path.sv
// tx_symbol_path: transmit baseband front end.
// Takes one QPSK symbol per input handshake (in_I, in_Q), maps each bit to
// +/-AMPLITUDE and upsamples by SPS onto an AXI-Stream-style {I,Q} stream.
// Build option TX_ZERO_STUFF_EN: when defined, only phase 0 of each symbol
// carries the mapped {I,Q} and phases 1..SPS-1 carry {0,0} (zero insertion);
// when undefined, every phase repeats the mapped {I,Q} (sample and hold).
module tx_symbol_path #(
    parameter int SAMPLE_WIDTH = 12,
    parameter int SPS          = 4,
    parameter int AMPLITUDE    = 1448
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_I,
    input  logic                      in_Q,
    input  logic [1:0]                in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [2*SAMPLE_WIDTH-1:0] out_data
);

    localparam int PHASE_W = (SPS > 1) ? $clog2(SPS) : 1;
    localparam logic [PHASE_W-1:0]      LAST_PHASE = PHASE_W'(SPS - 1);
    localparam logic [SAMPLE_WIDTH-1:0] LEVEL_POS  = SAMPLE_WIDTH'(AMPLITUDE);
    localparam logic [SAMPLE_WIDTH-1:0] LEVEL_NEG  = SAMPLE_WIDTH'(-AMPLITUDE);

    // Bit 0 maps to the positive level, bit 1 to the negative level.
    function automatic logic [SAMPLE_WIDTH-1:0] map_bit(input logic b);
        return b ? LEVEL_NEG : LEVEL_POS;
    endfunction

    // The reserved input carries nothing; fold it away explicitly.
    logic unused_in_data;
    assign unused_in_data = ^in_data;

    // sym_valid doubles as out_valid: a loaded symbol is always being presented.
    logic               sym_valid;
    logic [PHASE_W-1:0] phase;
    logic               out_fire;
    logic               sym_done;
    logic               in_fire;

    assign out_fire  = sym_valid & out_ready;
    assign sym_done  = out_fire & (phase == LAST_PHASE);
    // Accept a new symbol when empty, or when the last sample of the current
    // one leaves this cycle, so consecutive symbols stream without a gap.
    assign in_ready  = ~rst & (~sym_valid | sym_done);
    assign in_fire   = in_valid & in_ready;
    assign out_valid = sym_valid;

    // Symbol load, phase advance and drain of the presented sample.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register update based on
        // the pre-edge values, so the handshake terms above stay consistent.
        if (rst) begin
            sym_valid <= 1'b0;
            phase     <= '0;
            out_data  <= '0;
        end else if (in_fire) begin
            sym_valid <= 1'b1;
            phase     <= '0;
            out_data  <= {map_bit(in_I), map_bit(in_Q)};
        end else if (sym_done) begin
            sym_valid <= 1'b0;
            phase     <= '0;
            out_data  <= '0;
        end else if (out_fire) begin
            phase     <= phase + PHASE_W'(1);
`ifdef TX_ZERO_STUFF_EN
            out_data  <= '0;
`endif
        end
    end

endmodule

// File: tb/tb_tx_symbol_path.sv
// tb_tx_symbol_path: self-checking bench for tx_symbol_path.
// A queue-based model expands every accepted symbol into its SPS expected
// samples; a negedge monitor compares the DUT handshake and data against it.
// Honours TX_ZERO_STUFF_EN the same way the design does.
module tb_tx_symbol_path;

    localparam int SW  = 12;
    localparam int SPS = 4;
    localparam int AMP = 1448;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          in_I;
    logic          in_Q;
    logic [1:0]    in_data;
    logic          out_valid;
    logic          out_ready;
    logic [2*SW-1:0] out_data;

    int tests = 0;
    int fails = 0;

    tx_symbol_path #(
        .SAMPLE_WIDTH(SW),
        .SPS         (SPS),
        .AMPLITUDE   (AMP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_I     (in_I),
        .in_Q     (in_Q),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected sample for phase k of symbol (i,q), straight from the mapping rules.
    function automatic logic [2*SW-1:0] model_sample(input bit i, input bit q, input int k);
        int iv;
        int qv;
        logic [SW-1:0] a;
        logic [SW-1:0] b;
        iv = i ? -AMP : AMP;
        qv = q ? -AMP : AMP;
        a  = SW'(iv);
        b  = SW'(qv);
`ifdef TX_ZERO_STUFF_EN
        if (k != 0) return '0;
`endif
        return {a, b};
    endfunction

    // Model state: samples still owed by the DUT, in order.
    logic [2*SW-1:0] exp_q[$];
    logic [2*SW-1:0] cap[$];
    int              cap_cyc[$];
    int              cyc = 0;
    int              fires = 0;
    bit              prev_rst = 1'b0;
    bit              stalled_prev = 1'b0;
    logic [2*SW-1:0] held;
    bit              rand_ready = 1'b0;

    // Per-cycle compare against the model, then advance the model.
    always @(negedge clk) begin
        bit exp_rdy;
        cyc++;
        if (rst) begin
            check("rst_in_ready", in_ready, 0);
            if (prev_rst) begin
                check("rst_out_valid", out_valid, 0);
                check("rst_out_data", out_data, 0);
            end
            exp_q.delete();
        end else begin
            exp_rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready);
            check("in_ready", in_ready, exp_rdy);
            check("out_valid", out_valid, exp_q.size() > 0);
            if (exp_q.size() > 0) check("out_data", out_data, exp_q[0]);
            if (stalled_prev && out_valid) check("stall_hold", out_data, held);
            if (out_valid && out_ready) begin
                cap.push_back(out_data);
                cap_cyc.push_back(cyc);
                fires++;
            end
            if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
            if (in_valid && exp_rdy)
                for (int k = 0; k < SPS; k++) exp_q.push_back(model_sample(in_I, in_Q, k));
        end
        stalled_prev = !rst && out_valid && !out_ready;
        held         = out_data;
        prev_rst     = rst;
    end

    // Random backpressure when enabled.
    always @(posedge clk) begin
        #2;
        if (rand_ready) out_ready = 1'($urandom_range(1));
    end

    // Present one symbol and hold it until accepted; returns at posedge+1.
    task automatic send_sym(input bit i, input bit q);
        int n;
        in_valid = 1'b1;
        in_I     = i;
        in_Q     = q;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n >= 1000) begin
                tests++;
                fails++;
                $display("FAIL send_timeout: in_ready never rose");
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait until the model owes nothing; returns at posedge+1.
    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 4000) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d samples outstanding", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Hand-computed expectation for sample k of the directed (0,0),(0,1),(1,0),(1,1) run.
    function automatic logic [2*SW-1:0] lit(input int sym, input int k);
        logic [2*SW-1:0] tbl[4];
        tbl = '{24'h5A85A8, 24'h5A8A58, 24'hA585A8, 24'hA58A58};
`ifdef TX_ZERO_STUFF_EN
        if (k != 0) return '0;
`endif
        return tbl[sym];
    endfunction

    initial begin
        #1000000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timed out");
    end

    initial begin
        int f0;
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_I      = 1'b1;
        in_Q      = 1'b0;
        in_data   = 2'b00;
        out_ready = 1'b1;

        // Long reset with a symbol offered: nothing may be accepted or emitted.
        repeat (64) @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("ready_after_rst", in_ready, 1);
        @(posedge clk);
        #1;

        // Directed: four symbols, full throughput.
        cap.delete();
        cap_cyc.delete();
        send_sym(0, 0);
        send_sym(0, 1);
        send_sym(1, 0);
        send_sym(1, 1);
        wait_idle();
        check("dir_count", cap.size(), 16);
        if (cap.size() == 16) begin
            for (int k = 0; k < 16; k++) check($sformatf("dir_sample%0d", k), cap[k], lit(k / SPS, k % SPS));
            check("dir_gapless", cap_cyc[15] - cap_cyc[0], 15);
        end

        // Random symbols under random backpressure.
        f0 = fires;
        rand_ready = 1'b1;
        for (int s = 0; s < 200; s++) begin
            send_sym(1'($urandom_range(1)), 1'($urandom_range(1)));
            if ($urandom_range(3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        wait_idle();
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        check("rand_fires", fires - f0, 200 * SPS);

        // Source stops after three symbols: exactly 12 samples, then idle.
        f0 = fires;
        for (int s = 0; s < 3; s++) send_sym(1'($urandom_range(1)), 1'($urandom_range(1)));
        wait_idle();
        check("drop_fires", fires - f0, 3 * SPS);
        repeat (5) begin
            @(negedge clk);
            check("drop_idle_valid", out_valid, 0);
            check("drop_idle_ready", in_ready, 1);
        end
        @(posedge clk);
        #1;

        // Reset while phase 2 of a symbol is presented.
        send_sym(0, 1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", out_valid, 0);
        @(posedge clk);
        #1;
        cap.delete();
        send_sym(1, 0);
        wait_idle();
        check("post_rst_count", cap.size(), SPS);
        if (cap.size() == SPS)
            for (int k = 0; k < SPS; k++) check($sformatf("post_rst_sample%0d", k), cap[k], lit(2, k));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
